alu_ctrl_seq: RTL and testbench

Registered, handshaked ALU control stage for the RV32I/M execute path. It sits between the main decoder (ALUop, funct3, funct7 bits) and the ALU/multiply-divide datapath. It decodes one operation per transfer into an ALU control code. For M-extension operations it holds the result back for a parametrised multi-cycle latency, so the multiply/divide unit can run while upstream stalls. It also flags illegal ALUop/funct combinations and supports a pipeline flush.

---
 rtl/alu_ctrl_pkg.sv | 77 +++++++
 rtl/alu_ctrl_decode.sv | 55 +++++
 rtl/alu_ctrl_seq.sv | 107 ++++++++++
 tb/tb_alu_ctrl_seq.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared constants, types and helpers for the ALU control stage.
// Control codes are 5 bits; the top zero-extends them to CTRL_W.
package alu_ctrl_pkg;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_ITYPE = 4'b0010;
    localparam logic [3:0] OP_AUIPC = 4'b0011;
    localparam logic [3:0] OP_STORE = 4'b0100;
    localparam logic [3:0] OP_RTYPE = 4'b0110;
    localparam logic [3:0] OP_LUI   = 4'b0111;
    localparam logic [3:0] OP_BTYPE = 4'b1100;
    localparam logic [3:0] OP_JAL   = 4'b1101;

    localparam logic [4:0] C_ADD  = 5'b00000;
    localparam logic [4:0] C_SUB  = 5'b00010;
    localparam logic [4:0] C_SLL  = 5'b00100;
    localparam logic [4:0] C_SLT  = 5'b01000;
    localparam logic [4:0] C_SLTU = 5'b01100;
    localparam logic [4:0] C_XOR  = 5'b10000;
    localparam logic [4:0] C_SRL  = 5'b10100;
    localparam logic [4:0] C_SRA  = 5'b10110;
    localparam logic [4:0] C_OR   = 5'b11000;
    localparam logic [4:0] C_AND  = 5'b11100;
    localparam logic [4:0] C_LUI  = 5'b11111;
    localparam logic [4:0] C_BGE  = 5'b11010;
    localparam logic [4:0] C_BGEU = 5'b11110;

    localparam logic [4:0] C_MUL    = 5'b00001;
    localparam logic [4:0] C_MULH   = 5'b00101;
    localparam logic [4:0] C_MULHSU = 5'b01001;
    localparam logic [4:0] C_MULHU  = 5'b01101;
    localparam logic [4:0] C_DIV    = 5'b10001;
    localparam logic [4:0] C_DIVU   = 5'b10101;
    localparam logic [4:0] C_REM    = 5'b11001;
    localparam logic [4:0] C_REMU   = 5'b11101;

    localparam int CNT_W   = 6;
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 63;

    typedef enum logic [1:0] {IDLE, HOLD, MULTI} state_t;

    typedef struct packed {
        logic [4:0] code;
        logic       is_md;
        logic       is_div;
        logic       illegal;
    } dec_t;

    function automatic logic lat_ok(input int lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

    // Out-of-range latencies are clamped so the counter load always fits.
    function automatic logic [CNT_W-1:0] lat_cnt(input int lat);
        if (lat < LAT_MIN) return '0;
        if (lat > LAT_MAX) return 6'(LAT_MAX - 1);
        return 6'(lat - 1);
    endfunction

    function automatic logic [4:0] base_code(input logic [2:0] f3, input logic b5,
                                             input logic allow_sub);
        logic [4:0] c;
        case (f3)
            3'b000:  c = (allow_sub && b5) ? C_SUB : C_ADD;
            3'b001:  c = C_SLL;
            3'b010:  c = C_SLT;
            3'b011:  c = C_SLTU;
            3'b100:  c = C_XOR;
            3'b101:  c = b5 ? C_SRA : C_SRL;
            3'b110:  c = C_OR;
            default: c = C_AND;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of ALUop/funct fields into an ALU control code,
// M-extension flags and an illegal-combination flag.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter bit MEXT_EN = 1'b1
) (
    input  logic [3:0] aluop,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    input  logic       funct7_b0,
    output dec_t       dec
);

    always_comb begin
        dec = '0;
        case (aluop)
            OP_LOAD, OP_AUIPC, OP_STORE, OP_JAL: dec.code = C_ADD;
            OP_LUI:   dec.code = C_LUI;
            OP_RTYPE: begin
                if (MEXT_EN && funct7_b0) begin
                    dec.is_md  = 1'b1;
                    dec.is_div = funct3[2];
                    case (funct3)
                        3'b000:  dec.code = C_MUL;
                        3'b001:  dec.code = C_MULH;
                        3'b010:  dec.code = C_MULHSU;
                        3'b011:  dec.code = C_MULHU;
                        3'b100:  dec.code = C_DIV;
                        3'b101:  dec.code = C_DIVU;
                        3'b110:  dec.code = C_REM;
                        default: dec.code = C_REMU;
                    endcase
                end else begin
                    dec.code = base_code(funct3, funct7_b5, 1'b1);
                end
            end
            // ADDI has no subtract form, so bit 30 only matters for SRAI.
            OP_ITYPE: dec.code = base_code(funct3, funct7_b5, 1'b0);
            OP_BTYPE: begin
                case (funct3)
                    3'b000:  dec.code = C_SUB;
                    3'b001:  dec.code = C_XOR;
                    3'b100:  dec.code = C_SLT;
                    3'b101:  dec.code = C_BGE;
                    3'b110:  dec.code = C_SLTU;
                    3'b111:  dec.code = C_BGEU;
                    default: dec.illegal = 1'b1;
                endcase
            end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked ALU control stage: decodes one op per transfer and
// stalls M-extension ops for a configurable number of cycles before presenting them.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W  = 5,
    parameter bit MEXT_EN = 1'b1,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        aluop,
    input  logic [2:0]        funct3,
    input  logic              funct7_b5,
    input  logic              funct7_b0,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_md,
    output logic              out_illegal,
    output logic              busy
);

    localparam logic [CNT_W-1:0] MUL_CNT = lat_cnt(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = lat_cnt(DIV_LAT);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    dec_t               dec;
    logic               accept;
    logic [4:0]         ctrl_q;
    logic               md_q, illegal_q;

    alu_ctrl_decode #(.MEXT_EN(MEXT_EN)) u_decode (
        .aluop     (aluop),
        .funct3    (funct3),
        .funct7_b5 (funct7_b5),
        .funct7_b0 (funct7_b0),
        .dec       (dec)
    );

    // Handshake: a transfer happens on any rising edge where valid && ready;
    // valid never depends on ready, and held data stays stable until taken.
    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (accept) begin
            state_nxt = dec.is_md ? MULTI : HOLD;
            cnt_nxt   = dec.is_md ? (dec.is_div ? DIV_CNT : MUL_CNT) : '0;
        end else begin
            case (state)
                HOLD:    if (out_ready) state_nxt = IDLE;
                MULTI: begin
                    if (cnt == '0) state_nxt = HOLD;
                    else           cnt_nxt   = cnt - 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = !flush && ((state == IDLE) || ((state == HOLD) && out_ready));
        out_valid = (state == HOLD);
        busy      = (state == MULTI);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= '0;
            md_q      <= 1'b0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            ctrl_q    <= dec.code;
            md_q      <= dec.is_md;
            illegal_q <= dec.illegal;
        end
    end

    always_comb begin
        out_ctrl      = '0;
        out_ctrl[4:0] = ctrl_q;
    end

    assign out_md      = md_q;
    assign out_illegal = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: directed timing checks plus randomized ops scored
// against an arithmetic reference decode through an expected queue.
module tb_alu_ctrl_seq;

    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          flush, in_valid, in_ready, funct7_b5, funct7_b0;
    logic [3:0]    aluop;
    logic [2:0]    funct3;
    logic          out_valid, out_ready, out_md, out_illegal, busy;
    logic [CW-1:0] out_ctrl;
    logic          dir_ready, rnd_ready, rand_mode;

    logic          m0_in_valid, m0_in_ready, m0_b5, m0_b0, m0_out_valid, m0_out_ready;
    logic          m0_out_md, m0_out_illegal, m0_busy;
    logic [3:0]    m0_aluop;
    logic [2:0]    m0_funct3;
    logic [4:0]    m0_out_ctrl;

    assign out_ready = rand_mode ? rnd_ready : dir_ready;

    alu_ctrl_seq #(.CTRL_W(CW), .MEXT_EN(1'b1), .MUL_LAT(2), .DIV_LAT(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .funct3(funct3), .funct7_b5(funct7_b5), .funct7_b0(funct7_b0),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_md(out_md), .out_illegal(out_illegal), .busy(busy)
    );

    alu_ctrl_seq #(.CTRL_W(5), .MEXT_EN(1'b0), .MUL_LAT(2), .DIV_LAT(32)) dut_nom (
        .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(m0_in_valid), .in_ready(m0_in_ready),
        .aluop(m0_aluop), .funct3(m0_funct3), .funct7_b5(m0_b5), .funct7_b0(m0_b0),
        .out_valid(m0_out_valid), .out_ready(m0_out_ready), .out_ctrl(m0_out_ctrl),
        .out_md(m0_out_md), .out_illegal(m0_out_illegal), .busy(m0_busy)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [CW+1:0] exp_q[$];
    int got_cyc[$];
    logic [CW+1:0] mon_exp, mon_got;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference decode from the opcode rules: base codes are funct3*4, the
    // "alternate" forms add 2, M codes are funct3*4+1.
    function automatic logic [CW+1:0] model(input logic [3:0] op, input logic [2:0] f3,
                                            input logic b5, input logic b0, input bit mext);
        logic [4:0] btab [8];
        logic [4:0] code;
        logic md, ill;
        btab = '{5'b00010, 5'b10000, 5'b00000, 5'b00000,
                 5'b01000, 5'b11010, 5'b01100, 5'b11110};
        code = 5'b0; md = 1'b0; ill = 1'b0;
        if (op inside {4'b0000, 4'b0011, 4'b0100, 4'b1101}) code = 5'b00000;
        else if (op == 4'b0111) code = 5'b11111;
        else if (op == 4'b0110 && mext && b0) begin
            code = 5'(f3 * 4 + 1);
            md = 1'b1;
        end
        else if (op == 4'b0110) code = 5'(f3 * 4 + ((b5 && (f3 == 0 || f3 == 5)) ? 2 : 0));
        else if (op == 4'b0010) code = 5'(f3 * 4 + ((b5 && f3 == 5) ? 2 : 0));
        else if (op == 4'b1100) begin
            code = btab[f3];
            ill = (f3 == 3'd2 || f3 == 3'd3);
        end
        else ill = 1'b1;
        return {ill, md, 3'b000, code};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one op; push its expected result at the cycle it is accepted.
    task automatic send_op(input logic [3:0] op, input logic [2:0] f3, input logic b5,
                           input logic b0, output int acc);
        aluop = op; funct3 = f3; funct7_b5 = b5; funct7_b0 = b0; in_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (in_ready) begin
                acc = cyc;
                exp_q.push_back(model(op, f3, b5, b0, 1'b1));
                step();
                in_valid = 1'b0;
                return;
            end
            step();
        end
        in_valid = 1'b0;
        total++; bad++;
        $display("FAIL accept_timeout: op %b never accepted within 200 cycles", op);
    endtask

    task automatic wait_out(input int n, input string name);
        for (int i = 0; i < 100; i++) begin
            if (got_cyc.size() >= n) return;
            step();
        end
        total++; bad++;
        $display("FAIL %s: got %0d outputs expected %0d", name, got_cyc.size(), n);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total++;
            mon_got = {out_illegal, out_md, out_ctrl};
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: got %h expected nothing", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    bad++;
                    $display("FAIL output_data: got %h expected %h", mon_got, mon_exp);
                end
            end
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, a1, a2;
        logic [3:0] ops [15];
        logic [CW+1:0] e;
        logic [2:0] rf3;
        logic [3:0] rop;
        ops = '{4'b0000, 4'b0011, 4'b0100, 4'b1101, 4'b0111, 4'b0110, 4'b0110, 4'b0110,
                4'b0010, 4'b0010, 4'b1100, 4'b1100, 4'b1001, 4'b0001, 4'b1111};
        flush = 1'b0; in_valid = 1'b0; aluop = '0; funct3 = '0; funct7_b5 = 1'b0;
        funct7_b0 = 1'b0; dir_ready = 1'b0; rand_mode = 1'b0;
        m0_in_valid = 1'b0; m0_aluop = '0; m0_funct3 = '0; m0_b5 = 1'b0; m0_b0 = 1'b0;
        m0_out_ready = 1'b0;

        // reset values
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_out_md", out_md, 0);
        chk("rst_out_illegal", out_illegal, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        step();

        // streaming SUB, SRAI, BGEU with no bubbles
        dir_ready = 1'b1;
        got_cyc.delete();
        send_op(4'b0110, 3'b000, 1'b1, 1'b0, a);
        send_op(4'b0010, 3'b101, 1'b1, 1'b0, a1);
        send_op(4'b1100, 3'b111, 1'b0, 1'b0, a2);
        chk("stream_accept1", a1, a + 1);
        chk("stream_accept2", a2, a + 2);
        wait_out(3, "stream_outputs");
        if (got_cyc.size() >= 3) begin
            chk("stream_lat0", got_cyc[0], a + 1);
            chk("stream_lat1", got_cyc[1], a + 2);
            chk("stream_lat2", got_cyc[2], a + 3);
        end
        repeat (2) step();

        // MULHU with MUL_LAT=2
        got_cyc.delete();
        send_op(4'b0110, 3'b011, 1'b0, 1'b1, a);
        #1;
        chk("mul_busy_c1", busy, 1);
        chk("mul_in_ready_c1", in_ready, 0);
        chk("mul_out_valid_c1", out_valid, 0);
        step();
        #1;
        chk("mul_busy_c2", busy, 1);
        chk("mul_in_ready_c2", in_ready, 0);
        step();
        #1;
        chk("mul_out_valid_c3", out_valid, 1);
        chk("mul_busy_c3", busy, 0);
        wait_out(1, "mul_output");
        if (got_cyc.size() >= 1) chk("mul_latency", got_cyc[0] - a, 3);
        repeat (2) step();

        // DIV with DIV_LAT=32
        got_cyc.delete();
        send_op(4'b0110, 3'b100, 1'b0, 1'b1, a);
        wait_out(1, "div_output");
        if (got_cyc.size() >= 1) chk("div_latency", got_cyc[0] - a, 33);
        repeat (2) step();

        // M-extension disabled: DIV and SUB-with-bit25 decode as base R-type
        m0_out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m0_aluop = 4'b0110;
            m0_funct3 = (k == 0) ? 3'b100 : 3'b000;
            m0_b5 = (k == 1);
            m0_b0 = 1'b1;
            m0_in_valid = 1'b1;
            e = model(m0_aluop, m0_funct3, m0_b5, m0_b0, 1'b0);
            #1;
            chk("nom_in_ready", m0_in_ready, 1);
            step();
            m0_in_valid = 1'b0;
            #1;
            chk("nom_out_valid", m0_out_valid, 1);
            chk("nom_out_ctrl", m0_out_ctrl, e[4:0]);
            chk("nom_out_md", m0_out_md, e[CW]);
            chk("nom_busy", m0_busy, 0);
            step();
        end

        // backpressure: XOR held 3 cycles, then AND loads back-to-back
        dir_ready = 1'b0;
        got_cyc.delete();
        send_op(4'b0110, 3'b100, 1'b0, 1'b0, a);
        aluop = 4'b0110; funct3 = 3'b111; funct7_b5 = 1'b0; funct7_b0 = 1'b0;
        in_valid = 1'b1;
        e = model(4'b0110, 3'b100, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_held", {out_illegal, out_md, out_ctrl}, e);
            chk("bp_in_ready", in_ready, 0);
            step();
        end
        dir_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 1);
        exp_q.push_back(model(4'b0110, 3'b111, 1'b0, 1'b0, 1'b1));
        step();
        in_valid = 1'b0;
        #1;
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_data", {out_illegal, out_md, out_ctrl},
            model(4'b0110, 3'b111, 1'b0, 1'b0, 1'b1));
        wait_out(2, "bp_outputs");
        if (got_cyc.size() >= 2) chk("bp_no_bubble", got_cyc[1], got_cyc[0] + 1);
        repeat (2) step();

        // illegal combinations
        send_op(4'b1001, 3'b000, 1'b0, 1'b0, a);
        send_op(4'b1100, 3'b010, 1'b0, 1'b0, a);
        repeat (3) step();
        chk("illegal_drained", exp_q.size(), 0);

        // flush during MULTI with a competing in_valid
        got_cyc.delete();
        send_op(4'b0110, 3'b101, 1'b0, 1'b1, a);
        repeat (5) step();
        aluop = 4'b0110; funct3 = 3'b000; funct7_b5 = 1'b0; funct7_b0 = 1'b0;
        in_valid = 1'b1;
        flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        void'(exp_q.pop_back());
        #1;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_busy", busy, 0);
        chk("flush_in_ready_after", in_ready, 1);
        repeat (3) step();
        chk("flush_no_output", got_cyc.size(), 0);
        chk("flush_still_idle", out_valid, 0);

        // async reset in the middle of a DIV (cnt around 20)
        send_op(4'b0110, 3'b100, 1'b0, 1'b1, a);
        repeat (11) step();
        chk("midrst_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_ctrl", out_ctrl, 0);
        chk("midrst_out_md", out_md, 0);
        chk("midrst_out_illegal", out_illegal, 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        step();
        got_cyc.delete();
        send_op(4'b0000, 3'b010, 1'b0, 1'b0, a);
        wait_out(1, "midrst_output");
        if (got_cyc.size() >= 1) chk("midrst_idle_latency", got_cyc[0] - a, 1);

        // randomized ops with random downstream backpressure
        rand_mode = 1'b1;
        for (int n = 0; n < 150; n++) begin
            rop = ops[$urandom_range(0, 14)];
            rf3 = 3'($urandom_range(0, 7));
            send_op(rop, rf3, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), a);
            if ($urandom_range(0, 3) == 0) step();
        end
        rand_mode = 1'b0;
        dir_ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
        chk("random_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
